// File: rtl/mining_scheduler_if.sv
// Job/hash handshake bundle for mining_scheduler.
// master: the scheduler itself; slave: host plus hashing module side.
interface mining_scheduler_if #(
    parameter int unsigned NONCE_W = 32
);
    logic               job_valid;
    logic               job_ready;
    logic [NONCE_W-1:0] start_nonce;
    logic [NONCE_W-1:0] end_nonce;
    logic               abort;
    logic               begin_hash;
    logic               quit_hash;
    logic               hash_done;
    logic               below_target;
    logic [NONCE_W-1:0] nonce;
    logic               found;
    logic [NONCE_W-1:0] found_nonce;
    logic               exhausted;
    logic               timeout_err;
    logic               busy;
    logic [31:0]        hash_count;

    modport master (
        input  job_valid, start_nonce, end_nonce, abort, hash_done, below_target,
        output job_ready, begin_hash, quit_hash, nonce, found, found_nonce, exhausted,
               timeout_err, busy, hash_count
    );

    modport slave (
        output job_valid, start_nonce, end_nonce, abort, hash_done, below_target,
        input  job_ready, begin_hash, quit_hash, nonce, found, found_nonce, exhausted,
               timeout_err, busy, hash_count
    );
endinterface

// File: rtl/mining_scheduler.sv
// Walks the hashing module over an inclusive, wrapping nonce range for one job.
// Define MINING_SCHEDULER_HASH_COUNT_EN to enable the saturating hash_count register.
module mining_scheduler #(
    parameter int unsigned NONCE_W     = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic               clk,
    input logic               n_rst,
    mining_scheduler_if.master bus
);
    localparam int unsigned WDOG_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StWait, StFound, StExhaust, StAbort
    } state_t;

    state_t             state_q;
    logic [NONCE_W-1:0] end_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [NONCE_W-1:0] found_nonce_q;
    logic [WDOG_W-1:0]  wdog_q;
    logic               begin_hash_q;
    logic               quit_hash_q;
    logic               found_q;
    logic               exhausted_q;
    logic               timeout_q;

    // Strobes are registered alongside the transition into the state that owns them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            end_q         <= '0;
            nonce_q       <= '0;
            found_nonce_q <= '0;
            wdog_q        <= '0;
            begin_hash_q  <= 1'b0;
            quit_hash_q   <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            begin_hash_q <= 1'b0;
            quit_hash_q  <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            timeout_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.job_valid) begin
                        end_q         <= bus.end_nonce;
                        nonce_q       <= bus.start_nonce;
                        found_nonce_q <= '0;
                        begin_hash_q  <= 1'b1;
                        state_q       <= StStart;
                    end
                end
                StStart: begin
                    wdog_q <= '0;
                    if (bus.abort) begin
                        quit_hash_q <= 1'b1;
                        state_q     <= StAbort;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // abort beats hash_done, which beats the watchdog
                    if (bus.abort) begin
                        quit_hash_q <= 1'b1;
                        state_q     <= StAbort;
                    end else if (bus.hash_done) begin
                        if (bus.below_target) begin
                            found_nonce_q <= nonce_q;
                            found_q       <= 1'b1;
                            state_q       <= StFound;
                        end else if (nonce_q == end_q) begin
                            exhausted_q <= 1'b1;
                            state_q     <= StExhaust;
                        end else begin
                            nonce_q      <= nonce_q + 1'b1;
                            begin_hash_q <= 1'b1;
                            state_q      <= StStart;
                        end
                    end else if (wdog_q == WDOG_LAST) begin
                        timeout_q   <= 1'b1;
                        quit_hash_q <= 1'b1;
                        state_q     <= StAbort;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StFound, StExhaust, StAbort: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MINING_SCHEDULER_HASH_COUNT_EN
    logic [31:0] hash_count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hash_count_q <= '0;
        end else if (state_q == StIdle && bus.job_valid) begin
            hash_count_q <= '0;
        end else if (state_q == StWait && bus.hash_done && !bus.abort &&
                     hash_count_q != '1) begin
            hash_count_q <= hash_count_q + 32'd1;
        end
    end

    assign bus.hash_count = hash_count_q;
`else
    assign bus.hash_count = 32'd0;
`endif

    assign bus.job_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.begin_hash  = begin_hash_q;
    assign bus.quit_hash   = quit_hash_q;
    assign bus.found       = found_q;
    assign bus.exhausted   = exhausted_q;
    assign bus.timeout_err = timeout_q;
    assign bus.nonce       = nonce_q;
    assign bus.found_nonce = found_nonce_q;
endmodule

// File: doc/mining_scheduler.md
# mining_scheduler

Sequences the hashing module across a nonce range for one mining job. It accepts a job (start/end nonce), issues one `begin_hash` per nonce, and waits for `hash_done`. It checks the comparator's below-target flag and either reports a winning nonce, reports the range exhausted, or aborts the hash in flight. It sits between the host/job interface and the hashing module's controller.

## Interface
Parameters:
- `NONCE_W`, default 32: nonce width.
- `TIMEOUT_CYC`, default 1024: maximum cycles spent in WAIT for one nonce before a watchdog abort. Must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `job_valid` in 1: new job offered.
- `job_ready` out 1: scheduler can accept a job.
- `start_nonce` in NONCE_W: first nonce of the range, sampled on accept.
- `end_nonce` in NONCE_W: last nonce of the range (inclusive), sampled on accept.
- `abort` in 1: host cancels the current job.
- `begin_hash` out 1: one-cycle start pulse to the hashing module.
- `quit_hash` out 1: one-cycle cancel pulse to the hashing module.
- `hash_done` in 1: one-cycle completion pulse from the hashing module.
- `below_target` in 1: comparator result, valid only when `hash_done`=1.
- `nonce` out NONCE_W: nonce currently presented to the hashing module.
- `found` out 1: one-cycle pulse, winning nonce found.
- `found_nonce` out NONCE_W: winning nonce, held until the next accepted job.
- `exhausted` out 1: one-cycle pulse, range finished with no hit.
- `timeout_err` out 1: one-cycle pulse, watchdog fired.
- `busy` out 1: 1 in any state other than IDLE.
- `hash_count` out 32: number of `hash_done` events counted (see Configuration).

## Operation
States: IDLE, START, WAIT, FOUND, EXHAUST, ABORT.

- **IDLE:** `job_ready`=1. On `job_valid`:
  - latch `end_nonce`;
  - load `nonce`←`start_nonce`;
  - clear `found_nonce`;
  - clear `hash_count` (when enabled);
  - go to START.
- **START:** `begin_hash`=1; clear the watchdog counter; go to WAIT.
- **WAIT:** the watchdog increments every cycle. On `hash_done`:
  - if `below_target`=1: go to FOUND and register `found_nonce`←`nonce`;
  - else if `nonce`==latched end: go to EXHAUST;
  - else `nonce`←`nonce`+1 (mod 2^NONCE_W) and go to START.
  - If the watchdog reaches TIMEOUT_CYC with no `hash_done`: `timeout_err`=1, go to ABORT.
- **FOUND:** `found`=1; go to IDLE.
- **EXHAUST:** `exhausted`=1; go to IDLE.
- **ABORT:** `quit_hash`=1; go to IDLE.

Abort and boundary rules:
- `abort`=1 in START or WAIT sends the FSM to ABORT next cycle. `abort` has priority over `hash_done` and over the watchdog in the same cycle.
- `abort` is ignored in IDLE, FOUND, EXHAUST and ABORT. If `abort` and `job_valid` are both high in IDLE, the job is accepted.
- Wrap-around: if `end_nonce` < `start_nonce`, the range runs through 2^NONCE_W−1 to 0 and then to `end_nonce`.
- `start_nonce`==`end_nonce` means exactly one hash.
- `nonce`, `found_nonce` and `hash_count` are not reset by abort.
- Reset mid-job returns immediately to IDLE with no `quit_hash` pulse. The hashing module is reset by the same `n_rst`.

## Timing
- Reset values:
  - state IDLE, so `job_ready`=1 and `busy`=0;
  - `begin_hash`, `quit_hash`, `found`, `exhausted`, `timeout_err` all 0;
  - `nonce`, `found_nonce`, `hash_count` all 0.
- Strobes are decoded from the registered state (Moore) and are exactly one cycle wide.
- Job accepted at edge E: `begin_hash` is high in cycle E+1.
- `hash_done` at edge H: the next `begin_hash` is high in cycle H+1, with `nonce` already incremented. Per-nonce overhead is 2 cycles beyond hash latency.
- `found` or `exhausted` is high in cycle H+1. `job_ready` returns in cycle H+2.
- `abort` sampled at edge A: `quit_hash` is high in cycle A+1; IDLE from A+2.
- `found_nonce` is valid in the same cycle as `found`.
- `hash_done` outside WAIT is ignored.

## Configuration
- Macro `MINING_SCHEDULER_HASH_COUNT_EN`.
- **Defined:** `hash_count` is a 32-bit register.
  - Increments on every `hash_done` accepted in WAIT, including the final found or exhausted one.
  - Does not count `hash_done` in a cycle where `abort` wins.
  - Saturates at 2^32−1.
  - Cleared on job accept.
- **Undefined:** no counter logic; `hash_count` is tied to 0.

## Test plan
- Job start=5, end=7; `below_target`=0 on all hashes (hash latency 10 cycles) → `begin_hash` ×3 with `nonce`=5,6,7, then `exhausted` pulse, no `found`, `hash_count`=3.
- Job start=0x10, end=0x20; `below_target`=1 on the 3rd `hash_done` → `found` with `found_nonce`=0x12; no `begin_hash` afterwards; `found_nonce` held in IDLE.
- Job start=0xFFFFFFFE, end=0x1; no hit → nonces FFFFFFFE, FFFFFFFF, 0, 1, then `exhausted`.
- `abort` while in WAIT, same cycle as `hash_done` with `below_target`=1 → `quit_hash` next cycle, no `found`, IDLE after; an `abort` in IDLE has no effect.
- `hash_done` withheld, TIMEOUT_CYC=8 → `timeout_err` and `quit_hash`, then IDLE.
- `n_rst` low mid-WAIT → all outputs at reset values immediately; the next job works normally.
